// File: rtl/sram_burst_ctrl.sv
// Burst engine in front of the slow SRAM: expands one command into single-word
// strobes at wrapping addresses, with credit-limited reads into a small output FIFO.
module sram_burst_ctrl #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 1024,
   parameter int RD_LAT = 1,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_wr,
   input  logic [AW-1:0]    cmd_addr,
   input  logic [AW-1:0]    cmd_len,
   input  logic             wd_valid,
   output logic             wd_ready,
   input  logic [WIDTH-1:0] wd_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic             sram_wren,
   output logic             sram_rden,
   output logic [AW-1:0]    sram_addr,
   output logic [WIDTH-1:0] sram_wr_data,
   input  logic [WIDTH-1:0] sram_rd_data,
   output logic             busy,
   output logic             done
);

   localparam int FD = RD_LAT + 1;
   localparam int PW = (FD > 1) ? $clog2(FD) : 1;
   localparam int CW = $clog2(FD + 1) + 1;

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   state_t            state, state_next;
   logic [AW-1:0]     cur, count, cur_inc;
   logic [CW-1:0]     occ, inflight;
   logic [RD_LAT-1:0] vld;
   logic [WIDTH-1:0]  fifo_mem [FD];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic              accept, push, pop, credit, done_next, done_reg;

   assign cmd_ready = (state == IDLE);
   assign wd_ready  = (state == WRITE);
   assign busy      = (state != IDLE);
   assign done      = done_reg;
   assign sram_addr = cur;
   assign accept    = cmd_valid & cmd_ready;
   assign cur_inc   = (cur == AW'(DEPTH - 1)) ? '0 : cur + AW'(1);

   assign rd_valid  = (occ != '0);
   assign rd_data   = rd_valid ? fifo_mem[rd_ptr] : '0;
   assign pop       = rd_valid & rd_ready;
   assign push      = vld[RD_LAT-1];
   // A slot freed by this cycle's pop may be claimed by this cycle's issue.
   assign credit    = (occ + inflight) < (CW'(FD) + CW'(pop));

   always_comb begin
      state_next   = state;
      sram_wren    = 1'b0;
      sram_rden    = 1'b0;
      sram_wr_data = '0;
      done_next    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_next = cmd_wr ? WRITE : READ;
         end
         WRITE: begin
            sram_wr_data = wd_data;
            if (wd_valid) begin
               sram_wren = 1'b1;
               if (count == '0) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end
         end
         READ: begin
            if (credit) begin
               sram_rden = 1'b1;
               if (count == '0) state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (inflight == '0 && occ == CW'(1) && pop) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cur      <= '0;
         count    <= '0;
         occ      <= '0;
         inflight <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         done_reg <= 1'b0;
      end else begin
         state    <= state_next;
         done_reg <= done_next;
         if (accept) begin
            cur   <= cmd_addr;
            count <= cmd_len;
         end else if (sram_wren || sram_rden) begin
            cur   <= cur_inc;
            count <= count - AW'(1);
         end
         inflight <= inflight + CW'(sram_rden) - CW'(push);
         occ      <= occ + CW'(push) - CW'(pop);
         if (push) wr_ptr <= (wr_ptr == PW'(FD - 1)) ? '0 : wr_ptr + PW'(1);
         if (pop)  rd_ptr <= (rd_ptr == PW'(FD - 1)) ? '0 : rd_ptr + PW'(1);
      end
   end

   // Return tracker: bit k set means a read issued k+1 edges ago is still in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld[0] <= 1'b0;
      else     vld[0] <= sram_rden;
   end

   generate
      for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_vld
         always_ff @(posedge clk or posedge rst) begin
            if (rst) vld[gi] <= 1'b0;
            else     vld[gi] <= vld[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= sram_rd_data;
   end

endmodule
